exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Instruction sequencer: steps IDLE/FETCH/EXEC1/EXEC2/HALT, owns the program
// counter, the latched instruction and the retired-instruction count.
module exec_sequencer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        run,
  input  logic [15:0] instr_rdata,
  input  logic [15:0] rout,
  input  logic        jump,
  input  logic [15:0] stackout,
  input  logic        stack_full,
  input  logic        stack_empty,
  output logic [10:0] pc,
  output logic [15:0] ir,
  output logic        exec2,
  output logic        alu_en_n,
  output logic        reg_we,
  output logic        ram_we,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT
  } state_t;

  localparam logic [5:0] OP_MUL = 6'b011100;
  localparam logic [5:0] OP_MLA = 6'b011101;
  localparam logic [5:0] OP_MLS = 6'b011110;
  localparam logic [5:0] OP_CLL = 6'b100110;
  localparam logic [5:0] OP_RTN = 6'b100111;
  localparam logic [5:0] OP_PSH = 6'b101000;
  localparam logic [5:0] OP_POP = 6'b101001;
  localparam logic [5:0] OP_LDR = 6'b101010;
  localparam logic [5:0] OP_STR = 6'b101011;
  localparam logic [5:0] OP_STP = 6'b111111;

  state_t      state_q, state_d;
  logic [10:0] pc_d;
  logic [10:0] pc_inc;
  logic [5:0]  op;
  logic        retire;
  logic        fault_set;
  logic        unused_hi_bits;

  assign op             = ir[14:9];
  assign pc_inc         = pc + 11'd1;
  assign unused_hi_bits = ^{rout[15:11], stackout[15:11]};

  function automatic logic is_two_cycle(input logic [5:0] o);
    return (o == OP_MUL) || (o == OP_MLA) || (o == OP_MLS) ||
           (o == OP_RTN) || (o == OP_LDR);
  endfunction

  // Undefined codes 010111 and 100011 sit inside the writing ranges but are NOPs.
  function automatic logic writes_reg(input logic [5:0] o);
    return (o >= 6'd12 && o <= 6'd26 && o != 6'd23) ||
           (o >= 6'd28 && o <= 6'd31) ||
           (o >= 6'd32 && o <= 6'd36 && o != 6'd35) ||
           (o == OP_POP) || (o == OP_LDR);
  endfunction

  function automatic logic is_branch(input logic [5:0] o);
    return o <= 6'd11;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    retire     = 1'b0;
    fault_set  = 1'b0;
    reg_we     = 1'b0;
    ram_we     = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC1;
      S_EXEC1: begin
        if (op == OP_STP) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (((op == OP_PSH || op == OP_CLL) && stack_full) ||
                     ((op == OP_POP || op == OP_RTN) && stack_empty)) begin
          state_d   = S_HALT;
          fault_set = 1'b1;
        end else begin
          stack_push = (op == OP_PSH) || (op == OP_CLL);
          stack_pop  = (op == OP_POP) || (op == OP_RTN);
          ram_we     = (op == OP_STR);
          if (is_two_cycle(op)) begin
            state_d = S_EXEC2;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
            reg_we  = writes_reg(op);
            if ((is_branch(op) && jump) || op == OP_CLL) pc_d = rout[10:0];
            else                                          pc_d = pc_inc;
          end
        end
      end
      S_EXEC2: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        reg_we  = writes_reg(op);
        pc_d    = (op == OP_RTN) ? stackout[10:0] : pc_inc;
      end
      S_HALT:  if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An instruction aborted by reset must not write anything on the reset edge.
    if (!rstn) begin
      reg_we     = 1'b0;
      ram_we     = 1'b0;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc      <= 11'd0;
      ir      <= 16'd0;
      retired <= 16'd0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      if (state_q == S_FETCH) ir <= instr_rdata;
      if (retire)             retired <= retired + 16'd1;
      if (fault_set)          fault <= 1'b1;
    end
  end

  assign exec2    = (state_q == S_EXEC2);
  assign alu_en_n = !((state_q == S_EXEC1) || (state_q == S_EXEC2));
  assign halted   = (state_q == S_HALT);

endmodule
